ex_div: RTL and testbench
=========================

Name: ex_div

Overview:
- Multi-cycle 32-bit signed/unsigned integer divider for DIV/DIVU, instantiated beside the EX stage.
- Consumes operands and control that the ID/EX pipeline register delivers to EX.
- Returns {remainder, quotient} for the HI/LO write path.
- EX holds start_i high and raises a pipeline stall request until ready_o is seen.

Parameters:
DATA_W, 32, operand width; result is 2*DATA_W, iteration count is DATA_W.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
opdata1_i  in  DATA_W  dividend
opdata2_i  in  DATA_W  divisor
start_i  in  1  request; held high by EX until ready_o observed
annul_i  in  1  cancel in-flight division (flush/exception)
result_o  out  2*DATA_W  {remainder[DATA_W-1:0], quotient[DATA_W-1:0]}, registered
ready_o  out  1  result valid, registered

Behaviour:
Reset:
- rst sampled high at any edge, any state: state=FREE, counter=0, result_o=0, ready_o=0.
- Any operation in progress is discarded.

States: FREE, BYZERO, ON, END.

FREE:
- start_i=1 and annul_i=0 at edge N: latch signed_div_i, operand signs and |operands| (absolute values only when signed).
- Divisor==0: go to BYZERO.
- Otherwise: go to ON, counter=0, working reg (2*DATA_W+1 bits) = {0, |dividend|, 0}.
- start_i and annul_i both high: annul wins, stay FREE.
- Outputs remain 0 while in FREE.

ON (restoring shift-subtract, one quotient bit per edge):
- trial = {0, work[2W-1:W]} - {0, |divisor|}.
- trial MSB=1 (negative): work <<= 1.
- Else: work = {trial[W-1:0], work[W-1:0], 1}.
- counter++.
- After DATA_W iterations (edges N+1..N+32), at edge N+33:
  - Negate quotient if signed and operand signs differ.
  - Negate remainder if signed and dividend negative.
  - Register result_o, ready_o=1, go to END.
- annul_i=1 at any ON edge: go to FREE, counter=0, outputs stay 0, no result produced.

BYZERO:
- At edge N+1: result_o=0, ready_o=1, go to END.
- annul_i=1 at that edge: go to FREE instead, ready_o stays 0.

END:
- result_o and ready_o held stable while start_i=1; annul_i ignored.
- First edge sampling start_i=0: ready_o=0, result_o=0, go to FREE.
- A new start is accepted no earlier than the edge after that.

Operands and signed_div_i are latched at acceptance; later input changes are ignored until the next FREE acceptance.

Latency:
- Normal division: ready_o rises at edge N+33 (DATA_W+1).
- Divide by zero: ready_o rises at edge N+1.

Arithmetic:
- Signed overflow (-2^31 / -1): quotient wraps to 0x80000000, remainder 0.
- Unsigned operands with MSB set are treated as unsigned magnitudes; no sign fix-up.

Test Plan:
- Unsigned 100/7, start held from edge N -> ready_o=1 at N+33, result_o=0x00000002_0000000E; ready_o=0 at every edge before N+33.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD (r=-1, q=-3); signed 7/-2 -> 0x00000001_FFFFFFFD.
- Divide by zero, 5/0 signed and unsigned -> ready_o=1 at N+1, result_o=0; start_i dropped -> ready_o=0 next edge.
- annul_i pulsed at iteration 10 -> back to FREE, ready_o never asserts. New start 0xFFFFFFFF/1 unsigned -> result_o=0x00000000_FFFFFFFF at +33.
- Signed 0x80000000/0xFFFFFFFF -> result_o=0x00000000_80000000. Change opdata1_i mid-operation -> result unchanged.
- start_i held 5 cycles past ready_o -> result_o/ready_o stable; start low -> both 0 next edge. rst mid-ON -> outputs 0, FREE, next start completes correctly.

Source files
------------

// File: rtl/ex_div_if.sv
// Handshake and operand bundle between the EX stage and the multi-cycle divider.
// The master side belongs to EX and the slave side belongs to the divider.
interface ex_div_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i,
    output opdata1_i,
    output opdata2_i,
    output start_i,
    output annul_i,
    input  result_o,
    input  ready_o
  );

  modport slave (
    input  signed_div_i,
    input  opdata1_i,
    input  opdata2_i,
    input  start_i,
    input  annul_i,
    output result_o,
    output ready_o
  );
endinterface

// File: rtl/ex_div.sv
// Restoring shift-subtract DIV/DIVU unit beside EX: one quotient bit per cycle,
// result {remainder, quotient} held until EX drops start_i.
module ex_div #(
  parameter int unsigned DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  ex_div_if.slave     bus
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_FREE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [2*DATA_W:0]     r_work;
  logic [2*DATA_W:0]     w_work_nxt;
  logic [DATA_W-1:0]     r_abs2;
  logic [DATA_W-1:0]     w_abs2_nxt;
  logic                  r_negq;
  logic                  w_negq_nxt;
  logic                  r_negr;
  logic                  w_negr_nxt;
  logic [2*DATA_W-1:0]   r_result;
  logic [2*DATA_W-1:0]   w_result_nxt;
  logic                  r_ready;
  logic                  w_ready_nxt;

  logic [DATA_W-1:0]     w_abs1;
  logic [DATA_W-1:0]     w_abs2;
  logic [DATA_W:0]       w_trial;
  logic [DATA_W-1:0]     w_quot;
  logic [DATA_W-1:0]     w_rem;
  logic [DATA_W-1:0]     w_quot_fix;
  logic [DATA_W-1:0]     w_rem_fix;
  logic                  w_accept;

  // Magnitudes are taken only for DIV; DIVU operands pass through untouched.
  always_comb begin
    w_abs1 = bus.opdata1_i;
    w_abs2 = bus.opdata2_i;
    if (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) w_abs1 = -bus.opdata1_i;
    if (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) w_abs2 = -bus.opdata2_i;
  end

  // Work register layout: remainder in [2W:W+1], quotient bits shift into [W-1:0].
  always_comb begin
    w_trial    = {1'b0, r_work[2*DATA_W-1:DATA_W]} - {1'b0, r_abs2};
    w_quot     = r_work[DATA_W-1:0];
    w_rem      = r_work[2*DATA_W:DATA_W+1];
    w_quot_fix = r_negq ? -w_quot : w_quot;
    w_rem_fix  = r_negr ? -w_rem  : w_rem;
    w_accept   = bus.start_i && !bus.annul_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FREE;
      r_cnt    <= '0;
      r_work   <= '0;
      r_abs2   <= '0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_work   <= w_work_nxt;
      r_abs2   <= w_abs2_nxt;
      r_negq   <= w_negq_nxt;
      r_negr   <= w_negr_nxt;
      r_result <= w_result_nxt;
      r_ready  <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_work_nxt   = r_work;
    w_abs2_nxt   = r_abs2;
    w_negq_nxt   = r_negq;
    w_negr_nxt   = r_negr;
    w_result_nxt = r_result;
    w_ready_nxt  = r_ready;

    unique case (r_state)
      S_FREE: begin
        w_result_nxt = '0;
        w_ready_nxt  = 1'b0;
        w_cnt_nxt    = '0;
        if (w_accept) begin
          w_abs2_nxt = w_abs2;
          w_negq_nxt = bus.signed_div_i &&
                       (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
          w_negr_nxt = bus.signed_div_i && bus.opdata1_i[DATA_W-1];
          w_work_nxt = {{DATA_W{1'b0}}, w_abs1, 1'b0};
          if (bus.opdata2_i == '0) w_state_nxt = S_BYZERO;
          else                     w_state_nxt = S_ON;
        end
      end

      S_BYZERO: begin
        if (bus.annul_i) begin
          w_state_nxt = S_FREE;
        end else begin
          w_result_nxt = '0;
          w_ready_nxt  = 1'b1;
          w_state_nxt  = S_END;
        end
      end

      S_ON: begin
        if (bus.annul_i) begin
          w_state_nxt  = S_FREE;
          w_cnt_nxt    = '0;
          w_result_nxt = '0;
          w_ready_nxt  = 1'b0;
        end else if (r_cnt != CNT_W'(DATA_W)) begin
          if (w_trial[DATA_W]) w_work_nxt = {r_work[2*DATA_W-1:0], 1'b0};
          else                 w_work_nxt = {w_trial[DATA_W-1:0], r_work[DATA_W-1:0], 1'b1};
          w_cnt_nxt = r_cnt + 1'b1;
        end else begin
          w_result_nxt = {w_rem_fix, w_quot_fix};
          w_ready_nxt  = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_END;
        end
      end

      S_END: begin
        if (!bus.start_i) begin
          w_result_nxt = '0;
          w_ready_nxt  = 1'b0;
          w_state_nxt  = S_FREE;
        end
      end

      default: w_state_nxt = S_FREE;
    endcase
  end

  assign bus.result_o = r_result;
  assign bus.ready_o  = r_ready;

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: the driver queues expected {rem, quot} and arrival
// cycle; a negedge monitor pops on each ready_o rise and checks stability while held.
module tb_ex_div;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;

  logic [63:0] exp_q[$];
  int          cyc_q[$];

  ex_div_if #(.DATA_W(32)) bus ();

  ex_div #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    int q;
    int r;
    if (b == 32'd0) return 64'd0;
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
    return {r, q};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pop on every ready_o rise, verify value, arrival cycle, and hold stability.
  logic        m_prev_ready;
  logic [63:0] m_held;
  initial begin
    m_prev_ready = 1'b0;
    m_held       = '0;
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ready_o && !m_prev_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", {63'd0, bus.ready_o}, 64'd0);
        end else begin
          check("result", bus.result_o, exp_q.pop_front());
          check("latency_cycle", 64'(cyc), 64'(cyc_q.pop_front()));
        end
        m_held = bus.result_o;
      end else if (bus.ready_o && m_prev_ready) begin
        check("held_result", bus.result_o, m_held);
      end else if (!bus.ready_o) begin
        check("idle_result_zero", bus.result_o, 64'd0);
      end
    end
    m_prev_ready = bus.ready_o;
  end

  // abort_at < 0: normal run. Otherwise annul (or rst) sampled at acceptance edge + abort_at.
  task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input int abort_at, input bit use_rst);
    int  n_acc;
    bit  got;
    @(posedge clk); #1;
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    n_acc = cyc + 1;
    if (abort_at < 0) begin
      exp_q.push_back(model(sgn, a, b));
      cyc_q.push_back(n_acc + ((b == 32'd0) ? 1 : 33));
      repeat (3) @(posedge clk);
      #1;
      bus.opdata1_i    = $urandom;
      bus.opdata2_i    = $urandom;
      bus.signed_div_i = ~sgn;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        if (bus.ready_o) got = 1'b1;
      end
      check("ready_arrives", {63'd0, got}, 64'd1);
      repeat (hold) @(negedge clk);
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      @(posedge clk); #1;
      check("drop_start_clears", {bus.ready_o, bus.result_o[62:0]}, 64'd0);
    end else begin
      repeat (abort_at) @(posedge clk);
      #1;
      if (use_rst) begin
        rst         = 1'b1;
        bus.start_i = 1'b0;
      end else begin
        bus.annul_i = 1'b1;
      end
      @(posedge clk); #1;
      rst         = 1'b0;
      bus.annul_i = 1'b0;
      bus.start_i = 1'b0;
      check("abort_outputs_zero", {bus.ready_o, bus.result_o[62:0]}, 64'd0);
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.ready_o) got = 1'b1;
      end
      check("abort_no_ready", {63'd0, got}, 64'd0);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    bit          rs;
    cyc              = 0;
    n_checks         = 0;
    n_fail           = 0;
    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {bus.ready_o, bus.result_o[62:0]}, 64'd0);
    rst         = 1'b0;
    bus.start_i = 1'b0;

    do_div(1'b0, 32'd100, 32'd7, 0, -1, 1'b0);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, -1, 1'b0);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, -1, 1'b0);
    do_div(1'b1, 32'd5, 32'd0, 0, -1, 1'b0);
    do_div(1'b0, 32'd5, 32'd0, 2, -1, 1'b0);
    do_div(1'b0, 32'd100, 32'd7, 0, 10, 1'b0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0, -1, 1'b0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, -1, 1'b0);
    do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5, -1, 1'b0);
    do_div(1'b1, 32'd5, 32'd0, 0, 1, 1'b0);
    do_div(1'b1, 32'd12345, 32'hFFFF_FFB3, 0, 15, 1'b1);
    do_div(1'b1, 32'd12345, 32'hFFFF_FFB3, 0, -1, 1'b0);
    do_div(1'b1, 32'h8000_0000, 32'd3, 0, -1, 1'b0);

    for (int k = 0; k < 40; k++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'($urandom_range(0, 3));
        1: rb = rb >> $urandom_range(8, 30);
        2: rb = -(32'($urandom_range(1, 9)));
        default: ;
      endcase
      do_div(rs, ra, rb, $urandom_range(0, 3), -1, 1'b0);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
